sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode 7-segment display and its colon.
- Sits directly downstream of the clock/time-setting logic, which presents four BCD digits plus blank, blink and decimal-point masks.
- Owns IO_SSEG, IO_SSEGD and IO_SSEG_COL exclusively, so no other block drives display pins.
- Digit updates are double-buffered and applied only at scan-frame boundaries, so a digit never tears mid-frame.

Parameters:
REFRESH_TICKS, 49999, clock cycles per digit slot minus 1 (1 ms per digit at 50 MHz).
BLINK_TICKS, 24999999, clock cycles per blink half-period minus 1 (0.5 s at 50 MHz).

Ports:
M_CLOCK  input  1  system clock, 50 MHz; sole clock of the block.
M_RESET  input  1  synchronous reset, active-high.
upd_valid  input  1  one-cycle strobe; captures all upd_* inputs into the pending buffer.
upd_digits  input  16  BCD digits; [3:0]=digit0 (leftmost, hour tens) ... [15:12]=digit3.
upd_blank  input  4  per-digit force-off; bit n = digit n.
upd_blink  input  4  per-digit blink enable.
upd_dp  input  4  per-digit decimal point on.
upd_colon  input  2  [0]=colon on, [1]=colon blinks.
upd_busy  output  1  high while a pending update waits for the frame boundary.
IO_SSEG  output  8  segment cathodes, active-low; [7]=dp, [6:0]=g..a.
IO_SSEGD  output  4  digit anode enables, active-low; bit n = digit n.
IO_SSEG_COL  output  1  colon, active-low.

Behaviour:
- Reset (synchronous, M_RESET high at a rising edge):
  - IO_SSEG=8'hFF, IO_SSEGD=4'b1111, IO_SSEG_COL=1, upd_busy=0.
  - Refresh counter=0, digit index=0, blink counter=0, blink_phase=0 (visible).
  - Active and pending buffers cleared: blank=4'b1111, blink=0, dp=0, colon=0.
  - Reset overrides every other event in the same cycle, including upd_valid.
- Refresh counter:
  - Counts 0..REFRESH_TICKS, then wraps to 0.
  - On the wrap cycle (count==REFRESH_TICKS), the digit index increments mod 4.
- Frame boundary: a wrap cycle with index==3. On this cycle the index goes to 0 and, if upd_busy=1, the pending buffer copies into the active buffer and upd_busy clears.
- upd_valid:
  - Loads the pending buffer and sets upd_busy the next cycle.
  - A second upd_valid before the boundary overwrites the pending data; last write wins.
  - If upd_valid coincides with a frame boundary, the boundary applies the old pending data, then the new data is captured and upd_busy stays 1.
- Blink counter:
  - Counts 0..BLINK_TICKS, then wraps.
  - Each wrap toggles blink_phase.
  - Runs independently of scanning and updates.
- Outputs, registered, for digit index n (one-cycle latency from index change):
  - Dead time: on every refresh wrap cycle, IO_SSEGD is driven to 4'b1111 for that one cycle to prevent ghosting.
  - Otherwise IO_SSEGD = ~(1<<n), unless blank[n], or blink[n] with blink_phase=1; in either case IO_SSEGD=4'b1111.
  - IO_SSEG[6:0] decode of the digit value:
    - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h18.
    - 10..14 = 7'h3F (dash).
    - 15 = 7'h7F (blank).
  - IO_SSEG[7] = ~dp[n].
  - IO_SSEG_COL = ~(colon[0] & ~(colon[1] & blink_phase)). The colon is independent of scanning and not subject to dead time.
- Widths:
  - Refresh counter is $clog2(REFRESH_TICKS+1) bits; blink counter is $clog2(BLINK_TICKS+1) bits.
  - Both are compared with ==, never >, so no overshoot.
- Reset mid-frame: scanning restarts at digit 0 with all digits dark until the first update reaches the frame boundary.

Test Plan:
- Defaults: REFRESH_TICKS=3, BLINK_TICKS=19.
- Reset, then upd_valid with digits=16'h5321, blank=0 -> upd_busy=1 until the first frame boundary (cycle 16 after reset release). Then digit0 shows IO_SSEGD=4'b1110 with IO_SSEG=8'hF9, digit1 shows 4'b1101 with 8'hA4, digit2 shows 4'b1011 with 8'hB0, digit3 shows 4'b0111 with 8'h92. Each digit is enabled 3 cycles, with 1 dead cycle (4'b1111) between.
- Two upd_valid strobes (digits 16'h1111, then 16'h2222) inside one frame -> only 2s are ever displayed; upd_busy drops exactly at the boundary.
- blink=4'b0001 -> digit0 anode is dark for 20 cycles and lit for 20 cycles alternately; other digits are unaffected.
- colon=2'b11 -> IO_SSEG_COL toggles every 20 cycles. colon=2'b01 -> IO_SSEG_COL held at 0.
- digit value 4'hA with dp=1 -> IO_SSEG=8'h3F. Digit value 4'hF -> IO_SSEG=8'hFF.
- M_RESET asserted while digit2 is active -> next cycle all outputs are at reset values. upd_valid in the same cycle as reset is ignored (upd_busy=0).

Source files
------------

// File: rtl/sseg_scan_driver.sv
// Scans four 7-segment digits plus colon from a double-buffered image; outputs are registered (1 cycle after index change).
// No backpressure: upd_valid is always accepted, the newest pending image wins and upd_busy shows it has not yet reached a frame boundary.
module sseg_scan_driver #(
    parameter int REFRESH_TICKS = 49999,
    parameter int BLINK_TICKS   = 24999999
) (
    input  logic        M_CLOCK,
    input  logic        M_RESET,
    input  logic        upd_valid,
    input  logic [15:0] upd_digits,
    input  logic [3:0]  upd_blank,
    input  logic [3:0]  upd_blink,
    input  logic [3:0]  upd_dp,
    input  logic [1:0]  upd_colon,
    output logic        upd_busy,
    output logic [7:0]  IO_SSEG,
    output logic [3:0]  IO_SSEGD,
    output logic        IO_SSEG_COL
);

    localparam int RW = (REFRESH_TICKS < 1) ? 1 : $clog2(REFRESH_TICKS + 1);
    localparam int BW = (BLINK_TICKS < 1) ? 1 : $clog2(BLINK_TICKS + 1);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_TICKS);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_TICKS);

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [3:0]  dp;
        logic [1:0]  colon;
    } disp_t;

    // Digits reset to 4'hF so segment lines stay dark along with the anodes.
    localparam disp_t DISP_RESET = '{digits: 16'hFFFF, blank: 4'hF, blink: 4'h0, dp: 4'h0, colon: 2'b00};

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h18;
            4'd15:   s = 7'h7F;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [RW-1:0] r_refresh_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic [1:0]    r_digit_idx;
    logic          r_blink_phase;
    logic          r_busy;
    disp_t         r_active;
    disp_t         r_pending;
    logic [7:0]    r_sseg;
    logic [3:0]    r_ssegd;
    logic          r_col;

    logic          w_refresh_wrap;
    logic          w_blink_wrap;
    logic          w_frame_boundary;
    logic [3:0]    w_cur_digit;
    logic          w_anode_off;
    logic [3:0]    w_ssegd_nxt;
    logic [7:0]    w_sseg_nxt;
    logic          w_col_nxt;
    disp_t         w_upd;

    always_comb begin
        w_refresh_wrap   = (r_refresh_cnt == REFRESH_MAX);
        w_blink_wrap     = (r_blink_cnt == BLINK_MAX);
        w_frame_boundary = w_refresh_wrap && (r_digit_idx == 2'd3);

        w_upd.digits = upd_digits;
        w_upd.blank  = upd_blank;
        w_upd.blink  = upd_blink;
        w_upd.dp     = upd_dp;
        w_upd.colon  = upd_colon;

        w_cur_digit = r_active.digits[{r_digit_idx, 2'b00} +: 4];
        // Wrap cycle is forced dark so the next digit's segments never ghost onto the previous anode.
        w_anode_off = w_refresh_wrap
                    | r_active.blank[r_digit_idx]
                    | (r_active.blink[r_digit_idx] & r_blink_phase);
        w_ssegd_nxt = w_anode_off ? 4'b1111 : ~(4'b0001 << r_digit_idx);
        w_sseg_nxt  = {~r_active.dp[r_digit_idx], seg_decode(w_cur_digit)};
        w_col_nxt   = ~(r_active.colon[0] & ~(r_active.colon[1] & r_blink_phase));
    end

    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            r_refresh_cnt <= '0;
            r_blink_cnt   <= '0;
            r_digit_idx   <= 2'd0;
            r_blink_phase <= 1'b0;
            r_busy        <= 1'b0;
            r_active      <= DISP_RESET;
            r_pending     <= DISP_RESET;
            r_sseg        <= 8'hFF;
            r_ssegd       <= 4'b1111;
            r_col         <= 1'b1;
        end else begin
            if (w_refresh_wrap) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= r_digit_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + RW'(1);
            end

            if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end

            // Boundary consumes the old pending image first; a coincident strobe then refills it.
            if (w_frame_boundary && r_busy) begin
                r_active <= r_pending;
                r_busy   <= 1'b0;
            end
            if (upd_valid) begin
                r_pending <= w_upd;
                r_busy    <= 1'b1;
            end

            r_sseg  <= w_sseg_nxt;
            r_ssegd <= w_ssegd_nxt;
            r_col   <= w_col_nxt;
        end
    end

    assign upd_busy    = r_busy;
    assign IO_SSEG     = r_sseg;
    assign IO_SSEGD    = r_ssegd;
    assign IO_SSEG_COL = r_col;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed vector bench for sseg_scan_driver with small refresh/blink periods.
module tb_sseg_scan_driver;

    logic        M_CLOCK = 1'b0;
    logic        M_RESET = 1'b1;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_digits = 16'h0;
    logic [3:0]  upd_blank = 4'h0;
    logic [3:0]  upd_blink = 4'h0;
    logic [3:0]  upd_dp = 4'h0;
    logic [1:0]  upd_colon = 2'b00;
    logic        upd_busy;
    logic [7:0]  IO_SSEG;
    logic [3:0]  IO_SSEGD;
    logic        IO_SSEG_COL;

    sseg_scan_driver #(.REFRESH_TICKS(3), .BLINK_TICKS(19)) dut (
        .M_CLOCK     (M_CLOCK),
        .M_RESET     (M_RESET),
        .upd_valid   (upd_valid),
        .upd_digits  (upd_digits),
        .upd_blank   (upd_blank),
        .upd_blink   (upd_blink),
        .upd_dp      (upd_dp),
        .upd_colon   (upd_colon),
        .upd_busy    (upd_busy),
        .IO_SSEG     (IO_SSEG),
        .IO_SSEGD    (IO_SSEGD),
        .IO_SSEG_COL (IO_SSEG_COL)
    );

    always #5 M_CLOCK = ~M_CLOCK;

    localparam bit [3:0] M_D = 4'b1000;
    localparam bit [3:0] M_S = 4'b0100;
    localparam bit [3:0] M_B = 4'b0010;
    localparam bit [3:0] M_C = 4'b0001;

    typedef struct {
        bit          rst;
        int          cyc;
        bit          upd;
        logic [15:0] dig;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [3:0]  dp;
        logic [1:0]  colon;
        bit   [3:0]  mask;
        logic [3:0]  ssegd;
        logic [7:0]  sseg;
        logic        busy;
        logic        col;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t ck(input int c, input bit [3:0] m, input logic [3:0] d,
                                input logic [7:0] s, input logic b, input logic cl);
        vec_t v;
        v.rst = 1'b0; v.cyc = c; v.upd = 1'b0;
        v.dig = 16'h0; v.blank = 4'h0; v.blink = 4'h0; v.dp = 4'h0; v.colon = 2'b00;
        v.mask = m; v.ssegd = d; v.sseg = s; v.busy = b; v.col = cl;
        return v;
    endfunction

    function automatic vec_t up(input int c, input logic [15:0] dg, input logic [3:0] bl,
                                input logic [3:0] bk, input logic [3:0] p, input logic [1:0] co);
        vec_t v;
        v = ck(c, 4'b0000, 4'h0, 8'h00, 1'b0, 1'b0);
        v.upd = 1'b1; v.dig = dg; v.blank = bl; v.blink = bk; v.dp = p; v.colon = co;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge M_CLOCK);
        #1;
        upd_valid = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        M_RESET   = 1'b1;
        upd_valid = 1'b0;
        @(posedge M_CLOCK);
        @(posedge M_CLOCK);
        #1;
        M_RESET = 1'b0;
        cyc     = 0;
    endtask

    task automatic drive_upd(input logic [15:0] dg, input logic [3:0] bl, input logic [3:0] bk,
                             input logic [3:0] p, input logic [1:0] co);
        upd_digits = dg; upd_blank = bl; upd_blink = bk; upd_dp = p; upd_colon = co;
        upd_valid  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tmp;
        // Basic scan of 5321 after one update; frame boundaries end at cycles 15, 31, 47, 63, 79, 95.
        tmp = ck(0, M_D|M_S|M_B|M_C, 4'b1111, 8'hFF, 1'b0, 1'b1); tmp.rst = 1'b1; vecs.push_back(tmp);
        vecs.push_back(up(2, 16'h5321, 4'h0, 4'h0, 4'h0, 2'b00));
        vecs.push_back(ck(3,  M_B,     4'b0000, 8'h00, 1'b1, 1'b0));
        vecs.push_back(ck(15, M_D|M_B, 4'b1111, 8'h00, 1'b1, 1'b0));
        vecs.push_back(ck(16, M_D|M_B, 4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(17, M_D|M_S, 4'b1110, 8'hF9, 1'b0, 1'b0));
        vecs.push_back(ck(19, M_D|M_S, 4'b1110, 8'hF9, 1'b0, 1'b0));
        vecs.push_back(ck(20, M_D,     4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(21, M_D|M_S, 4'b1101, 8'hA4, 1'b0, 1'b0));
        vecs.push_back(ck(23, M_D|M_S, 4'b1101, 8'hA4, 1'b0, 1'b0));
        vecs.push_back(ck(24, M_D,     4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(25, M_D|M_S, 4'b1011, 8'hB0, 1'b0, 1'b0));
        vecs.push_back(ck(28, M_D,     4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(29, M_D|M_S, 4'b0111, 8'h92, 1'b0, 1'b0));
        vecs.push_back(ck(31, M_D|M_S, 4'b0111, 8'h92, 1'b0, 1'b0));
        vecs.push_back(ck(32, M_D,     4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(33, M_D|M_S|M_C, 4'b1110, 8'hF9, 1'b0, 1'b1));
        // Two strobes in one frame: only 2222 may appear.
        vecs.push_back(up(36, 16'h1111, 4'h0, 4'h0, 4'h0, 2'b00));
        vecs.push_back(ck(37, M_B, 4'b0000, 8'h00, 1'b1, 1'b0));
        vecs.push_back(up(40, 16'h2222, 4'h0, 4'h0, 4'h0, 2'b00));
        vecs.push_back(ck(45, M_D|M_S|M_B, 4'b0111, 8'h92, 1'b1, 1'b0));
        vecs.push_back(ck(47, M_B, 4'b0000, 8'h00, 1'b1, 1'b0));
        vecs.push_back(ck(48, M_B, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(49, M_D|M_S, 4'b1110, 8'hA4, 1'b0, 1'b0));
        vecs.push_back(ck(53, M_D|M_S, 4'b1101, 8'hA4, 1'b0, 1'b0));
        vecs.push_back(ck(57, M_D|M_S, 4'b1011, 8'hA4, 1'b0, 1'b0));
        // Strobe on the boundary cycle itself: 8888 is applied, 9764 stays pending.
        vecs.push_back(up(60, 16'h8888, 4'h0, 4'h0, 4'h0, 2'b00));
        vecs.push_back(ck(61, M_D|M_S|M_B, 4'b0111, 8'hA4, 1'b1, 1'b0));
        vecs.push_back(ck(63, M_B, 4'b0000, 8'h00, 1'b1, 1'b0));
        vecs.push_back(up(63, 16'h9764, 4'h0, 4'h0, 4'h0, 2'b00));
        vecs.push_back(ck(64, M_B, 4'b0000, 8'h00, 1'b1, 1'b0));
        vecs.push_back(ck(65, M_D|M_S|M_B, 4'b1110, 8'h80, 1'b1, 1'b0));
        vecs.push_back(ck(80, M_B, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(81, M_D|M_S, 4'b1110, 8'h99, 1'b0, 1'b0));
        vecs.push_back(ck(85, M_D|M_S, 4'b1101, 8'h82, 1'b0, 1'b0));
        vecs.push_back(ck(89, M_D|M_S, 4'b1011, 8'hF8, 1'b0, 1'b0));
        vecs.push_back(ck(93, M_D|M_S, 4'b0111, 8'h98, 1'b0, 1'b0));
        // Blink digit0, dash with dp, blank code, blinking colon; blink phase flips every 20 cycles.
        tmp = ck(0, M_D|M_S|M_B|M_C, 4'b1111, 8'hFF, 1'b0, 1'b1); tmp.rst = 1'b1; vecs.push_back(tmp);
        vecs.push_back(up(2, 16'h0FA8, 4'h0, 4'b0001, 4'b0010, 2'b11));
        vecs.push_back(ck(16, M_B|M_C, 4'b0000, 8'h00, 1'b0, 1'b1));
        vecs.push_back(ck(17, M_D|M_S|M_C, 4'b1110, 8'h80, 1'b0, 1'b0));
        vecs.push_back(ck(19, M_D|M_S, 4'b1110, 8'h80, 1'b0, 1'b0));
        vecs.push_back(ck(20, M_D|M_C, 4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(21, M_D|M_S|M_C, 4'b1101, 8'h3F, 1'b0, 1'b1));
        vecs.push_back(ck(25, M_D|M_S, 4'b1011, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(ck(29, M_D|M_S, 4'b0111, 8'hC0, 1'b0, 1'b0));
        vecs.push_back(ck(33, M_D|M_S, 4'b1111, 8'h80, 1'b0, 1'b0));
        vecs.push_back(ck(35, M_D, 4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(40, M_C, 4'b0000, 8'h00, 1'b0, 1'b1));
        vecs.push_back(ck(41, M_C, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(49, M_D|M_S, 4'b1110, 8'h80, 1'b0, 1'b0));
        vecs.push_back(ck(60, M_C, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(61, M_D|M_C, 4'b0111, 8'h00, 1'b0, 1'b1));
        vecs.push_back(ck(65, M_D, 4'b1111, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(81, M_D|M_S, 4'b1110, 8'h80, 1'b0, 1'b0));
        // Steady colon: held on even during the hidden blink phase.
        vecs.push_back(up(82, 16'h0FA8, 4'h0, 4'b0001, 4'b0010, 2'b01));
        vecs.push_back(ck(96, M_B, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(97, M_C, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(101, M_C, 4'b0000, 8'h00, 1'b0, 1'b0));
        vecs.push_back(ck(110, M_C, 4'b0000, 8'h00, 1'b0, 1'b0));

        cyc = 0;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            while (cyc < vecs[i].cyc) next_cycle();
            if (vecs[i].upd)
                drive_upd(vecs[i].dig, vecs[i].blank, vecs[i].blink, vecs[i].dp, vecs[i].colon);
            if (vecs[i].mask != 4'b0000) begin
                @(negedge M_CLOCK);
                if (vecs[i].mask[3]) cmp("ssegd", {4'h0, IO_SSEGD}, {4'h0, vecs[i].ssegd});
                if (vecs[i].mask[2]) cmp("sseg", IO_SSEG, vecs[i].sseg);
                if (vecs[i].mask[1]) cmp("busy", {7'h0, upd_busy}, {7'h0, vecs[i].busy});
                if (vecs[i].mask[0]) cmp("colon", {7'h0, IO_SSEG_COL}, {7'h0, vecs[i].col});
            end
        end

        // Reset while digit2 is lit, with a coincident strobe that must be dropped.
        do_reset();
        drive_upd(16'h5321, 4'h0, 4'h0, 4'h0, 2'b01);
        while (cyc < 26) next_cycle();
        @(negedge M_CLOCK);
        cmp("pre_rst_ssegd", {4'h0, IO_SSEGD}, 8'h0B);
        cmp("pre_rst_sseg", IO_SSEG, 8'hB0);
        M_RESET = 1'b1;
        drive_upd(16'h8888, 4'h0, 4'h0, 4'h0, 2'b01);
        @(posedge M_CLOCK);
        #1;
        M_RESET   = 1'b0;
        upd_valid = 1'b0;
        cyc       = 0;
        @(negedge M_CLOCK);
        cmp("rst_ssegd", {4'h0, IO_SSEGD}, 8'h0F);
        cmp("rst_sseg", IO_SSEG, 8'hFF);
        cmp("rst_colon", {7'h0, IO_SSEG_COL}, 8'h01);
        cmp("rst_busy", {7'h0, upd_busy}, 8'h00);
        while (cyc < 17) next_cycle();
        @(negedge M_CLOCK);
        cmp("post_rst_ssegd", {4'h0, IO_SSEGD}, 8'h0F);
        cmp("post_rst_busy", {7'h0, upd_busy}, 8'h00);
        cmp("post_rst_colon", {7'h0, IO_SSEG_COL}, 8'h01);
        while (cyc < 21) next_cycle();
        @(negedge M_CLOCK);
        cmp("post_rst_ssegd2", {4'h0, IO_SSEGD}, 8'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
